// File: rtl/gpio_apb_master_if.sv
// APB bus bundle between gpio_apb_master and the GPIO core register port.
// The master modport drives the request side; the slave modport answers it.
interface gpio_apb_master_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic [ADDR_W-1:0] paddr;
  logic              psel;
  logic              penable;
  logic              pwrite;
  logic [DATA_W-1:0] pwdata;
  logic [DATA_W-1:0] prdata;
  logic              pready;
  logic              pslverr;

  modport master (
    output paddr, psel, penable, pwrite, pwdata,
    input  prdata, pready, pslverr
  );

  modport slave (
    input  paddr, psel, penable, pwrite, pwdata,
    output prdata, pready, pslverr
  );
endinterface

// File: rtl/gpio_apb_master.sv
// Single-transfer APB initiator for the GPIO register port: turns one valid/ready
// command into a SETUP/ACCESS pair and returns one response with error/timeout status.
module gpio_apb_master #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 16
) (
  input  logic              sys_clk,
  input  logic              sys_rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic              rsp_timeout,
  output logic              busy,
  gpio_apb_master_if.master apb
);

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_t;

  // Counter must hold TIMEOUT; a zero TIMEOUT still needs one bit to exist.
  localparam int                CNT_W   = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CNT_W-1:0]  TO_LAST = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
  localparam logic [CNT_W-1:0]  CNT_MAX = '1;

  state_t           state;
  logic [CNT_W-1:0] wait_cnt;

  // NOTE: every register here is assigned with <= so all updates in a cycle see
  // the pre-edge values; blocking assignments would make ordering matter.
  always_ff @(posedge sys_clk or negedge sys_rst) begin
    if (!sys_rst) begin
      state       <= IDLE;
      wait_cnt    <= '0;
      cmd_ready   <= 1'b1;
      busy        <= 1'b0;
      rsp_valid   <= 1'b0;
      rsp_rdata   <= '0;
      rsp_err     <= 1'b0;
      rsp_timeout <= 1'b0;
      apb.paddr   <= '0;
      apb.psel    <= 1'b0;
      apb.penable <= 1'b0;
      apb.pwrite  <= 1'b0;
      apb.pwdata  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (cmd_valid) begin
            cmd_ready  <= 1'b0;
            busy       <= 1'b1;
            wait_cnt   <= '0;
            apb.paddr  <= cmd_addr;
            apb.pwrite <= cmd_write;
            apb.pwdata <= cmd_wdata;
            if (cmd_addr[1:0] == 2'b00) begin
              state    <= SETUP;
              apb.psel <= 1'b1;
            end else begin
              // Misaligned: report an error without touching the bus.
              state       <= RESP;
              rsp_valid   <= 1'b1;
              rsp_err     <= 1'b1;
              rsp_timeout <= 1'b0;
              rsp_rdata   <= '0;
            end
          end
        end

        SETUP: begin
          state       <= ACCESS;
          apb.penable <= 1'b1;
        end

        ACCESS: begin
          if (apb.pready) begin
            state       <= RESP;
            apb.psel    <= 1'b0;
            apb.penable <= 1'b0;
            rsp_valid   <= 1'b1;
            rsp_err     <= apb.pslverr;
            rsp_timeout <= 1'b0;
            rsp_rdata   <= (!apb.pwrite && !apb.pslverr) ? apb.prdata : '0;
          end else begin
            if (wait_cnt != CNT_MAX) wait_cnt <= wait_cnt + 1'b1;
            // Abort on the TIMEOUT-th consecutive stalled ACCESS cycle.
            if (TIMEOUT != 0 && wait_cnt == TO_LAST) begin
              state       <= RESP;
              apb.psel    <= 1'b0;
              apb.penable <= 1'b0;
              rsp_valid   <= 1'b1;
              rsp_err     <= 1'b1;
              rsp_timeout <= 1'b1;
              rsp_rdata   <= '0;
            end
          end
        end

        RESP: begin
          if (rsp_ready) begin
            state     <= IDLE;
            rsp_valid <= 1'b0;
            wait_cnt  <= '0;
            cmd_ready <= 1'b1;
            busy      <= 1'b0;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_gpio_apb_master.sv
// Directed bench for gpio_apb_master with TIMEOUT=4; the bench plays the APB slave
// and checks bus phases, response contents and handshake timing cycle by cycle.
module tb_gpio_apb_master;

  logic        sys_clk;
  logic        sys_rst;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_write;
  logic [31:0] cmd_addr;
  logic [31:0] cmd_wdata;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        rsp_timeout;
  logic        busy;

  int tests = 0;
  int fails = 0;

  gpio_apb_master_if #(.ADDR_W(32), .DATA_W(32)) apb ();

  gpio_apb_master #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(4)) dut (
    .sys_clk     (sys_clk),
    .sys_rst     (sys_rst),
    .cmd_valid   (cmd_valid),
    .cmd_ready   (cmd_ready),
    .cmd_write   (cmd_write),
    .cmd_addr    (cmd_addr),
    .cmd_wdata   (cmd_wdata),
    .rsp_valid   (rsp_valid),
    .rsp_ready   (rsp_ready),
    .rsp_rdata   (rsp_rdata),
    .rsp_err     (rsp_err),
    .rsp_timeout (rsp_timeout),
    .busy        (busy),
    .apb         (apb.master)
  );

  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  // Advance to just after the next rising edge, where outputs are stable.
  task automatic tick();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic issue(input logic wr, input logic [31:0] addr, input logic [31:0] wdata);
    cmd_valid = 1'b1;
    cmd_write = wr;
    cmd_addr  = addr;
    cmd_wdata = wdata;
    tick();
    cmd_valid = 1'b0;
  endtask

  task automatic test_reset();
    sys_rst   = 1'b0;
    cmd_valid = 1'b0;
    cmd_write = 1'b0;
    cmd_addr  = '0;
    cmd_wdata = '0;
    rsp_ready = 1'b0;
    apb.pready  = 1'b0;
    apb.prdata  = '0;
    apb.pslverr = 1'b0;
    #12;
    tests++; if (cmd_ready !== 1'b1) begin fails++; $display("FAIL rst_cmd_ready got %0h want 1", cmd_ready); end
    tests++; if (rsp_valid !== 1'b0) begin fails++; $display("FAIL rst_rsp_valid got %0h want 0", rsp_valid); end
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL rst_busy got %0h want 0", busy); end
    tests++; if ({apb.psel, apb.penable, apb.pwrite} !== 3'b000) begin fails++; $display("FAIL rst_apb_ctl got %b want 000", {apb.psel, apb.penable, apb.pwrite}); end
    tests++; if (apb.paddr !== 32'h0 || apb.pwdata !== 32'h0) begin fails++; $display("FAIL rst_apb_data got %h/%h want 0/0", apb.paddr, apb.pwdata); end
    tests++; if ({rsp_err, rsp_timeout} !== 2'b00 || rsp_rdata !== 32'h0) begin fails++; $display("FAIL rst_rsp got %b/%h want 00/0", {rsp_err, rsp_timeout}, rsp_rdata); end
    sys_rst = 1'b1;
    tick();
  endtask

  task automatic finish_rsp(input string tag);
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    tests++; if (rsp_valid !== 1'b0 || cmd_ready !== 1'b1 || busy !== 1'b0) begin fails++; $display("FAIL %s_done got valid=%0h ready=%0h busy=%0h want 0/1/0", tag, rsp_valid, cmd_ready, busy); end
  endtask

  task automatic test_write_zero_wait();
    apb.pready = 1'b1;
    issue(1'b1, 32'h04, 32'hAAAA_AAAA);
    tests++; if (apb.psel !== 1'b1 || apb.penable !== 1'b0) begin fails++; $display("FAIL wr_setup got psel=%0h pen=%0h want 1/0", apb.psel, apb.penable); end
    tests++; if (apb.pwrite !== 1'b1 || apb.paddr !== 32'h04 || apb.pwdata !== 32'hAAAA_AAAA) begin fails++; $display("FAIL wr_bus got w=%0h a=%h d=%h want 1/4/aaaaaaaa", apb.pwrite, apb.paddr, apb.pwdata); end
    tests++; if (cmd_ready !== 1'b0 || busy !== 1'b1) begin fails++; $display("FAIL wr_busy got ready=%0h busy=%0h want 0/1", cmd_ready, busy); end
    tick();
    tests++; if (apb.psel !== 1'b1 || apb.penable !== 1'b1 || rsp_valid !== 1'b0) begin fails++; $display("FAIL wr_access got psel=%0h pen=%0h rv=%0h want 1/1/0", apb.psel, apb.penable, rsp_valid); end
    tick();
    tests++; if (rsp_valid !== 1'b1 || apb.psel !== 1'b0 || apb.penable !== 1'b0) begin fails++; $display("FAIL wr_resp got rv=%0h psel=%0h pen=%0h want 1/0/0", rsp_valid, apb.psel, apb.penable); end
    tests++; if (rsp_err !== 1'b0 || rsp_rdata !== 32'h0) begin fails++; $display("FAIL wr_rsp_data got err=%0h rd=%h want 0/0", rsp_err, rsp_rdata); end
    finish_rsp("wr");
  endtask

  task automatic test_read_wait();
    apb.pready = 1'b0;
    apb.prdata = 32'hFFFF_FFFF;
    issue(1'b0, 32'h14, 32'h0);
    tests++; if (apb.psel !== 1'b1 || apb.pwrite !== 1'b0 || apb.paddr !== 32'h14) begin fails++; $display("FAIL rd_setup got psel=%0h w=%0h a=%h want 1/0/14", apb.psel, apb.pwrite, apb.paddr); end
    for (int c = 1; c <= 3; c++) begin
      tick();
      tests++; if (apb.penable !== 1'b1 || apb.psel !== 1'b1 || rsp_valid !== 1'b0) begin fails++; $display("FAIL rd_access%0d got pen=%0h psel=%0h rv=%0h want 1/1/0", c, apb.penable, apb.psel, rsp_valid); end
    end
    tests++; if (apb.paddr !== 32'h14) begin fails++; $display("FAIL rd_addr_stable got %h want 14", apb.paddr); end
    apb.pready = 1'b1;
    apb.prdata = 32'h1234_5678;
    tick();
    apb.pready = 1'b0;
    tests++; if (rsp_valid !== 1'b1 || apb.psel !== 1'b0) begin fails++; $display("FAIL rd_resp got rv=%0h psel=%0h want 1/0", rsp_valid, apb.psel); end
    tests++; if (rsp_rdata !== 32'h1234_5678 || rsp_err !== 1'b0) begin fails++; $display("FAIL rd_data got %h err=%0h want 12345678/0", rsp_rdata, rsp_err); end
    finish_rsp("rd");
  endtask

  task automatic test_slverr();
    apb.pready  = 1'b1;
    apb.pslverr = 1'b1;
    apb.prdata  = 32'hDEAD_BEEF;
    issue(1'b1, 32'h0C, 32'h0000_5A5A);
    tick();
    tick();
    apb.pslverr = 1'b0;
    tests++; if (rsp_valid !== 1'b1 || rsp_err !== 1'b1 || rsp_timeout !== 1'b0) begin fails++; $display("FAIL slverr_flags got rv=%0h err=%0h to=%0h want 1/1/0", rsp_valid, rsp_err, rsp_timeout); end
    tests++; if (rsp_rdata !== 32'h0) begin fails++; $display("FAIL slverr_rdata got %h want 0", rsp_rdata); end
    finish_rsp("slverr");
  endtask

  task automatic test_timeout();
    apb.pready = 1'b0;
    apb.prdata = 32'h1111_2222;
    issue(1'b0, 32'h18, 32'h0);
    for (int c = 1; c <= 4; c++) begin
      tick();
      if (c < 4) begin
        tests++; if (apb.penable !== 1'b1 || rsp_valid !== 1'b0) begin fails++; $display("FAIL to_access%0d got pen=%0h rv=%0h want 1/0", c, apb.penable, rsp_valid); end
      end
    end
    // Fourth ACCESS cycle is now in progress; abort lands on the next edge.
    tests++; if (apb.penable !== 1'b1) begin fails++; $display("FAIL to_access4 got pen=%0h want 1", apb.penable); end
    tick();
    tests++; if (apb.psel !== 1'b0 || rsp_valid !== 1'b1) begin fails++; $display("FAIL to_abort got psel=%0h rv=%0h want 0/1", apb.psel, rsp_valid); end
    tests++; if (rsp_err !== 1'b1 || rsp_timeout !== 1'b1 || rsp_rdata !== 32'h0) begin fails++; $display("FAIL to_rsp got err=%0h to=%0h rd=%h want 1/1/0", rsp_err, rsp_timeout, rsp_rdata); end
    apb.pready = 1'b1;
    tick();
    apb.pready = 1'b0;
    tests++; if (rsp_timeout !== 1'b1 || rsp_rdata !== 32'h0 || apb.psel !== 1'b0) begin fails++; $display("FAIL to_late_ready got to=%0h rd=%h psel=%0h want 1/0/0", rsp_timeout, rsp_rdata, apb.psel); end
    finish_rsp("to");
  endtask

  task automatic test_ready_on_last_wait();
    apb.pready = 1'b0;
    issue(1'b0, 32'h20, 32'h0);
    tick();
    tick();
    tick();
    tick();
    apb.pready = 1'b1;
    apb.prdata = 32'hCAFE_F00D;
    tick();
    apb.pready = 1'b0;
    tests++; if (rsp_valid !== 1'b1 || rsp_timeout !== 1'b0 || rsp_err !== 1'b0) begin fails++; $display("FAIL edge_flags got rv=%0h to=%0h err=%0h want 1/0/0", rsp_valid, rsp_timeout, rsp_err); end
    tests++; if (rsp_rdata !== 32'hCAFE_F00D) begin fails++; $display("FAIL edge_rdata got %h want cafef00d", rsp_rdata); end
    finish_rsp("edge");
  endtask

  task automatic test_misaligned();
    apb.pready = 1'b1;
    issue(1'b0, 32'h06, 32'h0);
    tests++; if (rsp_valid !== 1'b1 || rsp_err !== 1'b1 || rsp_rdata !== 32'h0) begin fails++; $display("FAIL mis_rsp got rv=%0h err=%0h rd=%h want 1/1/0", rsp_valid, rsp_err, rsp_rdata); end
    for (int c = 1; c <= 5; c++) begin
      tests++; if (apb.psel !== 1'b0 || rsp_valid !== 1'b1 || rsp_err !== 1'b1 || cmd_ready !== 1'b0) begin fails++; $display("FAIL mis_hold%0d got psel=%0h rv=%0h err=%0h rdy=%0h want 0/1/1/0", c, apb.psel, rsp_valid, rsp_err, cmd_ready); end
      tick();
    end
    apb.pready = 1'b0;
    finish_rsp("mis");
  endtask

  task automatic test_reset_mid_transfer();
    apb.pready = 1'b0;
    issue(1'b1, 32'h10, 32'h0000_00FF);
    tick();
    tests++; if (apb.penable !== 1'b1) begin fails++; $display("FAIL mrst_pre got pen=%0h want 1", apb.penable); end
    sys_rst = 1'b0;
    #1;
    tests++; if ({apb.psel, apb.penable, rsp_valid, busy} !== 4'b0000) begin fails++; $display("FAIL mrst_async got %b want 0000", {apb.psel, apb.penable, rsp_valid, busy}); end
    #2;
    sys_rst = 1'b1;
    tick();
    tests++; if (cmd_ready !== 1'b1 || rsp_valid !== 1'b0) begin fails++; $display("FAIL mrst_idle got rdy=%0h rv=%0h want 1/0", cmd_ready, rsp_valid); end
    apb.pready = 1'b1;
    issue(1'b1, 32'h08, 32'h0000_0055);
    tick();
    tick();
    tests++; if (rsp_valid !== 1'b1 || rsp_err !== 1'b0 || apb.pwdata !== 32'h55 || apb.paddr !== 32'h08) begin fails++; $display("FAIL mrst_after got rv=%0h err=%0h d=%h a=%h want 1/0/55/8", rsp_valid, rsp_err, apb.pwdata, apb.paddr); end
    finish_rsp("mrst");
  endtask

  task automatic test_back_to_back();
    int rsp_cnt;
    rsp_cnt    = 0;
    apb.pready = 1'b1;
    rsp_ready  = 1'b1;
    cmd_valid  = 1'b1;
    cmd_write  = 1'b1;
    cmd_addr   = 32'h00;
    cmd_wdata  = 32'h0F0F_0F0F;
    for (int c = 0; c < 12; c++) begin
      tick();
      if (rsp_valid === 1'b1) rsp_cnt++;
    end
    cmd_valid = 1'b0;
    rsp_ready = 1'b0;
    apb.pready = 1'b0;
    tests++; if (rsp_cnt !== 3) begin fails++; $display("FAIL b2b_rate got %0d want 3", rsp_cnt); end
    tests++; if (cmd_ready !== 1'b1) begin fails++; $display("FAIL b2b_end got rdy=%0h want 1", cmd_ready); end
  endtask

  initial begin
    test_reset();
    test_write_zero_wait();
    test_read_wait();
    test_slverr();
    test_timeout();
    test_ready_on_last_wait();
    test_misaligned();
    test_reset_mid_transfer();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
